grid_game_model: RTL and testbench

Parametrised board-game state engine: the successor to the fixed 3x3 tic-tac-toe game model, generalised to a SIZE x SIZE board with a WIN_LEN-in-a-row rule. It accepts one-hot cursor moves from the button controller. It validates each move and alternates players. It runs a fixed-latency win/draw check and keeps per-player and draw score counters. The board vectors feed the VGA display and the score counters feed the seven-segment driver.

---
 rtl/grid_game_pkg.sv | 20 ++
 rtl/grid_run_counter.sv | 57 +++++
 rtl/grid_game_model.sv | 140 ++++++++++++++
 tb/tb_grid_game_model.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_game_pkg.sv
// Shared types for the grid game engine: FSM states, check directions and
// cell index decoding.
package grid_game_pkg;

  typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} stateT;
  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_A} dirT;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } rcT;

  function automatic rcT idxToRc(input int idx, input int size);
    rcT rc;
    rc.row = 3'(idx / size);
    rc.col = 3'(idx % size);
    return rc;
  endfunction

endpackage

// File: rtl/grid_run_counter.sv
// Combinational run length through (row,col) along one direction, counting
// both ways, clipped at the board edges and capped at WIN_LEN-1 per side.
module grid_run_counter
  import grid_game_pkg::*;
#(
  parameter int SIZE    = 3,
  parameter int WIN_LEN = 3
) (
  input  logic [SIZE*SIZE-1:0] board,
  input  logic [2:0]           row,
  input  logic [2:0]           col,
  input  dirT                  dir,
  output logic [3:0]           runLen
);

  localparam int CELLS = SIZE*SIZE;
  localparam int IW    = $clog2(CELLS);

  always_comb begin
    int dr, dc, r, c;
    logic fwdOn, bwdOn;
    logic [3:0] cnt;
    logic [IW-1:0] pos;
    dr = 0;
    dc = 1;
    case (dir)
      DIR_H:   begin dr = 0; dc = 1;  end
      DIR_V:   begin dr = 1; dc = 0;  end
      DIR_D:   begin dr = 1; dc = 1;  end
      DIR_A:   begin dr = 1; dc = -1; end
      default: begin dr = 0; dc = 1;  end
    endcase
    cnt   = 4'd1;
    fwdOn = 1'b1;
    bwdOn = 1'b1;
    pos   = '0;
    // A side stops at the first empty cell or the board edge; no row wrap.
    for (int k = 1; k < WIN_LEN; k++) begin
      r = int'(row) + k*dr;
      c = int'(col) + k*dc;
      if (fwdOn && r >= 0 && r < SIZE && c >= 0 && c < SIZE) begin
        pos = IW'(r*SIZE + c);
        if (board[pos]) cnt = cnt + 4'd1;
        else fwdOn = 1'b0;
      end else fwdOn = 1'b0;
      r = int'(row) - k*dr;
      c = int'(col) - k*dc;
      if (bwdOn && r >= 0 && r < SIZE && c >= 0 && c < SIZE) begin
        pos = IW'(r*SIZE + c);
        if (board[pos]) cnt = cnt + 4'd1;
        else bwdOn = 1'b0;
      end else bwdOn = 1'b0;
    end
    runLen = cnt;
  end

endmodule

// File: rtl/grid_game_model.sv
// SIZE x SIZE board game engine: move validation, 4-cycle win/draw check
// through the placed cell, player alternation and saturating scores.
module grid_game_model
  import grid_game_pkg::*;
#(
  parameter int SIZE    = 3,
  parameter int WIN_LEN = 3,
  parameter int SCORE_W = 4
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [SIZE*SIZE-1:0] C,
  input  logic                 writeEn,
  input  logic                 newGame,
  output logic [SIZE*SIZE-1:0] X,
  output logic [SIZE*SIZE-1:0] O,
  output logic                 turnO,
  output logic                 busy,
  output logic                 gameOver,
  output logic                 winnerO,
  output logic                 isDraw,
  output logic                 moveErr,
  output logic [SCORE_W-1:0]   xScore,
  output logic [SCORE_W-1:0]   oScore,
  output logic [SCORE_W-1:0]   drawScore
);

  localparam int CELLS = SIZE*SIZE;
  localparam int IW    = $clog2(CELLS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  stateT         state, nextState;
  rcT            placed;
  logic [1:0]    dirCnt;
  logic          winFlag, startO, legal, winNow, boardFull;
  logic [IW-1:0] cIdx;
  logic [3:0]    runLen;

  always_comb begin
    cIdx = '0;
    for (int i = 0; i < CELLS; i++)
      if (C[i]) cIdx = IW'(i);
  end

  assign legal     = $onehot(C) && ((X | O) & C) == '0;
  assign boardFull = &(X | O);
  assign winNow    = winFlag || (runLen >= 4'(WIN_LEN));

  // One counter shared by the four CHECK cycles; dirCnt selects the direction.
  grid_run_counter #(.SIZE(SIZE), .WIN_LEN(WIN_LEN)) runCounter (
    .board  (turnO ? O : X),
    .row    (placed.row),
    .col    (placed.col),
    .dir    (dirT'(dirCnt)),
    .runLen (runLen)
  );

  always_comb begin
    nextState = state;
    if (newGame) nextState = PLAY;
    else begin
      case (state)
        PLAY:    if (writeEn && legal) nextState = CHECK;
        CHECK:   if (dirCnt == 2'd3)
                   nextState = winNow ? WIN : (boardFull ? DRAW : PLAY);
        default: nextState = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state    <= PLAY;
      busy     <= 1'b0;
      gameOver <= 1'b0;
      isDraw   <= 1'b0;
    end else begin
      state    <= nextState;
      busy     <= (nextState == CHECK);
      gameOver <= (nextState == WIN) || (nextState == DRAW);
      isDraw   <= (nextState == DRAW);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      X         <= '0;
      O         <= '0;
      turnO     <= 1'b0;
      startO    <= 1'b0;
      winnerO   <= 1'b0;
      moveErr   <= 1'b0;
      winFlag   <= 1'b0;
      dirCnt    <= '0;
      placed    <= '0;
      xScore    <= '0;
      oScore    <= '0;
      drawScore <= '0;
    end else begin
      moveErr <= 1'b0;
      if (newGame) begin
        X       <= '0;
        O       <= '0;
        startO  <= ~startO;
        turnO   <= ~startO;
        winnerO <= 1'b0;
        winFlag <= 1'b0;
        dirCnt  <= '0;
      end else begin
        case (state)
          PLAY: if (writeEn) begin
            if (legal) begin
              if (turnO) O <= O | C;
              else       X <= X | C;
              placed  <= idxToRc(int'(cIdx), SIZE);
              dirCnt  <= '0;
              winFlag <= 1'b0;
            end else moveErr <= 1'b1;
          end
          CHECK: begin
            dirCnt  <= dirCnt + 2'd1;
            winFlag <= winNow;
            if (dirCnt == 2'd3) begin
              if (winNow) begin
                winnerO <= turnO;
                if (turnO) begin
                  if (oScore != SCORE_MAX) oScore <= oScore + 1'b1;
                end else if (xScore != SCORE_MAX) xScore <= xScore + 1'b1;
              end else if (boardFull) begin
                if (drawScore != SCORE_MAX) drawScore <= drawScore + 1'b1;
              end else turnO <= ~turnO;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_grid_game_model.sv
// Scoreboard bench: a whole-board reference game model predicts each moveErr
// pulse and each CHECK result; a negedge monitor pops and compares.
module tb_grid_game_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetN, we, ng;
  logic [24:0] C;
  int          sel;

  logic [8:0]  x3, o3;
  logic [24:0] x5, o5;
  logic        t3, b3, g3, w3, d3, e3, t5, b5, g5, w5, d5, e5;
  logic [3:0]  xs3, os3, ds3, xs5, os5, ds5;

  grid_game_model #(.SIZE(3), .WIN_LEN(3), .SCORE_W(4)) dut3 (
    .clk(clk), .resetN(resetN), .C(C[8:0]), .writeEn(we && sel == 0),
    .newGame(ng && sel == 0), .X(x3), .O(o3), .turnO(t3), .busy(b3),
    .gameOver(g3), .winnerO(w3), .isDraw(d3), .moveErr(e3),
    .xScore(xs3), .oScore(os3), .drawScore(ds3));

  grid_game_model #(.SIZE(5), .WIN_LEN(4), .SCORE_W(4)) dut5 (
    .clk(clk), .resetN(resetN), .C(C), .writeEn(we && sel == 1),
    .newGame(ng && sel == 1), .X(x5), .O(o5), .turnO(t5), .busy(b5),
    .gameOver(g5), .winnerO(w5), .isDraw(d5), .moveErr(e5),
    .xScore(xs5), .oScore(os5), .drawScore(ds5));

  logic [24:0] mX, mO;
  logic        mTurnO, mBusy, mOver, mWin, mDraw, mErr;
  logic [3:0]  mXs, mOs, mDs;

  always_comb begin
    if (sel == 0) begin
      mX = {16'b0, x3}; mO = {16'b0, o3}; mTurnO = t3; mBusy = b3; mOver = g3;
      mWin = w3; mDraw = d3; mErr = e3; mXs = xs3; mOs = os3; mDs = ds3;
    end else begin
      mX = x5; mO = o5; mTurnO = t5; mBusy = b5; mOver = g5;
      mWin = w5; mDraw = d5; mErr = e5; mXs = xs5; mOs = os5; mDs = ds5;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          kind;   // 0 = moveErr pulse, 1 = busy falling
    logic [24:0] x, o;
    bit          turn, over, draw, winO;
    int          xs, os, ds;
    int          len;    // expected busy length, 0 = not checked
  } expT;

  expT q[$];
  int  b[25];
  int  sz, wl, xsc, osc, dsc;
  bit  gOver, gDraw, gWinO, gTurn, gStart;
  int  vectors = 0, miscompares = 0;

  function automatic logic [24:0] boardVec(int who);
    logic [24:0] v = '0;
    for (int i = 0; i < sz*sz; i++) if (b[i] == who) v[i] = 1'b1;
    return v;
  endfunction

  function automatic expT snap(int kind, int len);
    expT e;
    e.kind = kind; e.x = boardVec(1); e.o = boardVec(2);
    e.turn = gTurn; e.over = gOver; e.draw = gDraw; e.winO = gWinO;
    e.xs = xsc; e.os = osc; e.ds = dsc; e.len = len;
    return e;
  endfunction

  // Any wl-long straight line of `who` anywhere on the board.
  function automatic bit lineWin(int who);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    for (int r = 0; r < sz; r++)
      for (int c = 0; c < sz; c++)
        for (int d = 0; d < 4; d++) begin
          bit ok = 1;
          for (int k = 0; k < wl; k++) begin
            int rr = r + k*dr[d];
            int cc = c + k*dc[d];
            if (rr < 0 || rr >= sz || cc < 0 || cc >= sz) ok = 0;
            else if (b[rr*sz+cc] != who) ok = 0;
          end
          if (ok) return 1;
        end
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    foreach (b[i]) b[i] = 0;
    gOver = 0; gDraw = 0; gWinO = 0; gTurn = 0; gStart = 0;
    xsc = 0; osc = 0; dsc = 0;
  endtask

  task automatic modelNewGame();
    foreach (b[i]) b[i] = 0;
    gStart = !gStart; gTurn = gStart; gOver = 0; gDraw = 0; gWinO = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic waitIdle();
    int n = 0;
    while ((mBusy === 1'b1 || q.size() != 0) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) begin
      vectors++; miscompares++;
      $display("FAIL timeout: busy=%b pending=%0d, expected idle", mBusy, q.size());
      q.delete();
    end
  endtask

  task automatic rawMove(input logic [24:0] cv);
    C = cv; we = 1; @(posedge clk); #1; we = 0; C = '0;
  endtask

  task automatic applyMove(input logic [24:0] cv);
    bit   expectBusy = 0;
    int   idx = 0, who;
    if (!gOver) begin
      for (int i = 0; i < sz*sz; i++) if (cv[i]) idx = i;
      if ($countones(cv) == 1 && b[idx] == 0) begin
        who = gTurn ? 2 : 1;
        b[idx] = who;
        if (lineWin(who)) begin
          gOver = 1; gWinO = gTurn;
          if (gTurn) osc = (osc < 15) ? osc + 1 : 15;
          else       xsc = (xsc < 15) ? xsc + 1 : 15;
        end else if ($countones(boardVec(1) | boardVec(2)) == sz*sz) begin
          gOver = 1; gDraw = 1; dsc = (dsc < 15) ? dsc + 1 : 15;
        end else gTurn = !gTurn;
        q.push_back(snap(1, 4));
        expectBusy = 1;
      end else q.push_back(snap(0, 0));
    end
    rawMove(cv);
    if (expectBusy) waitIdle();
  endtask

  task automatic mv(input int idx);
    logic [24:0] cv = '0;
    cv[idx] = 1'b1;
    applyMove(cv);
  endtask

  task automatic pulseNewGame(input bit expectEvent);
    modelNewGame();
    if (expectEvent) q.push_back(snap(1, 0));
    ng = 1; @(posedge clk); #1; ng = 0;
  endtask

  task automatic doReset(input bit expectEvent);
    modelReset();
    if (expectEvent) q.push_back(snap(1, 0));
    resetN = 0; @(posedge clk); #1; resetN = 1;
  endtask

  task automatic setup(input int s);
    sel = s; sz = s ? 5 : 3; wl = s ? 4 : 3;
    doReset(0);
  endtask

  task automatic randomGame(input int moves);
    logic [24:0] cv, mask;
    mask = (25'd1 << (sz*sz)) - 25'd1;
    for (int i = 0; i < moves && !gOver; i++) begin
      if ($urandom_range(0, 7) == 0) cv = 25'($urandom) & mask;
      else begin
        cv = '0;
        cv[$urandom_range(0, sz*sz-1)] = 1'b1;
      end
      applyMove(cv);
    end
    if (gOver) mv(0);  // ignored: no moveErr expected
    waitIdle();
    pulseNewGame(0);
  endtask

  // ---------------- monitor ----------------
  bit prevBusy = 0;
  int busyLen = 0;

  task automatic handleEvent(input int kind);
    expT e;
    if (q.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL unexpected event kind=%0d at t=%0t, expected none", kind, $time);
      return;
    end
    e = q.pop_front();
    chk("eventKind", kind, e.kind);
    chk("X", mX, e.x);
    chk("O", mO, e.o);
    chk("turnO", mTurnO, e.turn);
    chk("gameOver", mOver, e.over);
    chk("isDraw", mDraw, e.draw);
    if (e.over && !e.draw) chk("winnerO", mWin, e.winO);
    chk("xScore", mXs, e.xs);
    chk("oScore", mOs, e.os);
    chk("drawScore", mDs, e.ds);
    if (e.len != 0) chk("busyCycles", busyLen, e.len);
  endtask

  always @(negedge clk) begin
    if (mBusy === 1'b1) busyLen++;
    if (mErr === 1'b1) handleEvent(0);
    if (prevBusy && mBusy !== 1'b1) begin
      handleEvent(1);
      busyLen = 0;
    end
    prevBusy = (mBusy === 1'b1);
  end

  // ---------------- stimulus ----------------
  initial begin
    resetN = 0; we = 0; ng = 0; C = '0; sel = 0; sz = 3; wl = 3;
    modelReset();
    repeat (2) @(posedge clk);
    #1 resetN = 1;
    chk("rst X", mX, 0); chk("rst O", mO, 0); chk("rst turnO", mTurnO, 0);
    chk("rst busy", mBusy, 0); chk("rst gameOver", mOver, 0);
    chk("rst winnerO", mWin, 0); chk("rst isDraw", mDraw, 0);
    chk("rst moveErr", mErr, 0); chk("rst scores", {mXs, mOs, mDs}, 0);

    // X wins top row
    mv(0); mv(3); mv(1); mv(4); mv(2);
    chk("win gameOver", mOver, 1); chk("win xScore", mXs, 1);

    // occupied cell, empty and multi-bit cursor
    setup(0);
    mv(4); mv(4);
    applyMove(25'd0); applyMove(25'b11);
    waitIdle();
    chk("err turnO", mTurnO, 1); chk("err O", mO, 0);

    // draw, then O starts next game
    setup(0);
    mv(0); mv(1); mv(2); mv(4); mv(3); mv(5); mv(7); mv(6); mv(8);
    chk("draw isDraw", mDraw, 1); chk("draw score", mDs, 1);
    pulseNewGame(0);
    chk("ng X", mX, 0); chk("ng turnO", mTurnO, 1);

    // newGame aborts CHECK
    rawMove(25'd1 << 4);
    @(posedge clk); #1;
    pulseNewGame(1);
    waitIdle();
    chk("abort busy", mBusy, 0);

    // newGame and writeEn together: move discarded
    modelNewGame();
    C = 25'd1 << 2; we = 1; ng = 1; @(posedge clk); #1; we = 0; ng = 0; C = '0;
    chk("ng+we X", mX, 0); chk("ng+we O", mO, 0);

    // reset mid-game in PLAY, then during CHECK
    mv(0); mv(1);
    doReset(0);
    chk("mid rst X", mX, 0); chk("mid rst O", mO, 0); chk("mid rst turnO", mTurnO, 0);
    chk("mid rst scores", {mXs, mOs, mDs}, 0);
    mv(0); mv(3); mv(1); mv(4);
    rawMove(25'd1 << 2);
    @(posedge clk); #1;
    doReset(1);
    waitIdle();

    // oScore saturation across 16 O wins
    setup(0);
    for (int g = 0; g < 16; g++) begin
      if (!gStart) begin mv(0); mv(3); mv(1); mv(4); mv(8); mv(5); end
      else         begin mv(3); mv(0); mv(4); mv(1); mv(5); end
      pulseNewGame(0);
    end
    chk("oScore sat", mOs, 15);

    setup(0);
    for (int g = 0; g < 12; g++) randomGame(40);

    // 5x5, 4 in a row: anti-diagonal win, and a row-wrapping run that must not win
    setup(1);
    mv(3); mv(0); mv(7); mv(1); mv(11); mv(2); mv(15);
    chk("anti win", mOver, 1);
    setup(1);
    mv(3); mv(10); mv(4); mv(11); mv(5); mv(12); mv(6);
    chk("wrap no win", mOver, 0);
    setup(1);
    for (int g = 0; g < 10; g++) randomGame(80);

    waitIdle();
    if (q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL scoreboard: %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
